// File: rtl/clock_mode_ctrl.sv
// Mode/sub-state controller for the clock, stopwatch and alarm display path.
// Turns one-cycle button pulses, the 1 Hz tick and alarm match into a display-select code.
module clock_mode_ctrl #(
  parameter int RING_SECS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_sel,
  input  logic       btn_start,
  input  logic       tick_1hz,
  input  logic       alarm_hit,
  output logic [4:0] state,
  output logic       stw_en,
  output logic       stw_clr,
  output logic       lap_hold,
  output logic       aset_inc,
  output logic [1:0] aset_field,
  output logic       buzzer
);

  typedef enum logic [1:0] {
    MODE_CLOCK = 2'd0,
    MODE_STW   = 2'd1,
    MODE_ASET  = 2'd2
  } mode_t;

  localparam logic [1:0] STW_IDLE  = 2'b00;
  localparam logic [1:0] STW_RUN   = 2'b01;
  localparam logic [1:0] STW_PAUSE = 2'b11;
  localparam logic [1:0] STW_LAP   = 2'b10;
  localparam logic [5:0] RING_LIMIT = 6'(RING_SECS);

  mode_t      mode_reg, mode_next;
  logic [1:0] sub_reg, sub_next;
  logic [1:0] stw_sub_reg, stw_sub_next;
  logic       ringing_reg, ringing_next;
  logic [5:0] ring_cnt_reg, ring_cnt_next;
  logic       ring_vis_reg, ring_vis_next;
  logic       alarm_q_reg;

  logic       any_btn;
  logic       alarm_edge;
  logic       act;
  logic       stw_clr_next;
  logic       aset_inc_next;
  logic [1:0] disp_sub;
  logic [4:0] state_next;
  logic [1:0] aset_field_next;

  assign any_btn    = btn_mode | btn_sel | btn_start;
  assign alarm_edge = alarm_hit & ~alarm_q_reg;

  always_comb begin
    mode_next     = mode_reg;
    sub_next      = sub_reg;
    stw_sub_next  = stw_sub_reg;
    ringing_next  = ringing_reg;
    ring_cnt_next = ring_cnt_reg;
    ring_vis_next = ring_vis_reg;
    stw_clr_next  = 1'b0;
    aset_inc_next = 1'b0;
    act           = 1'b1;

    // A button pressed while ringing only dismisses the ring.
    if (ringing_reg) begin
      if (any_btn) begin
        ringing_next  = 1'b0;
        ring_vis_next = 1'b0;
        act           = 1'b0;
      end else if (tick_1hz) begin
        ring_cnt_next = ring_cnt_reg + 6'd1;
        ring_vis_next = ~ring_vis_reg;
        if (ring_cnt_next == RING_LIMIT) begin
          ringing_next  = 1'b0;
          ring_vis_next = 1'b0;
        end
      end
    end else if (alarm_edge) begin
      ringing_next  = 1'b1;
      ring_cnt_next = 6'd0;
      ring_vis_next = 1'b1;
    end

    if (act) begin
      if (btn_mode) begin
        sub_next = 2'b00;
        case (mode_reg)
          MODE_CLOCK: mode_next = MODE_STW;
          MODE_STW:   mode_next = MODE_ASET;
          default:    mode_next = MODE_CLOCK;
        endcase
      end else if (btn_sel) begin
        case (mode_reg)
          MODE_CLOCK: begin
            case (sub_reg)
              2'b00:   sub_next = 2'b01;
              2'b01:   sub_next = 2'b10;
              default: sub_next = 2'b00;
            endcase
          end
          MODE_STW: begin
            case (stw_sub_reg)
              STW_RUN:   stw_sub_next = STW_LAP;
              STW_LAP:   stw_sub_next = STW_RUN;
              STW_PAUSE: begin
                stw_sub_next = STW_IDLE;
                stw_clr_next = 1'b1;
              end
              default:   stw_sub_next = stw_sub_reg;
            endcase
          end
          default: begin
            case (sub_reg)
              2'b00:   sub_next = 2'b01;
              2'b01:   sub_next = 2'b11;
              2'b11:   sub_next = 2'b10;
              default: sub_next = 2'b00;
            endcase
          end
        endcase
      end else if (btn_start) begin
        if (mode_reg == MODE_STW) begin
          case (stw_sub_reg)
            STW_IDLE:  stw_sub_next = STW_RUN;
            STW_RUN:   stw_sub_next = STW_PAUSE;
            STW_PAUSE: stw_sub_next = STW_RUN;
            default:   stw_sub_next = stw_sub_reg;
          endcase
        end else if (mode_reg == MODE_ASET && sub_reg != 2'b00) begin
          aset_inc_next = 1'b1;
        end
      end
    end

    // The stopwatch keeps its own sub so it survives leaving and re-entering STW.
    disp_sub   = (mode_next == MODE_STW) ? stw_sub_next : sub_next;
    state_next = {mode_next == MODE_STW, mode_next == MODE_ASET, disp_sub,
                  ring_vis_next & (mode_next == MODE_CLOCK)};

    aset_field_next = 2'd0;
    if (mode_next == MODE_ASET) begin
      case (sub_next)
        2'b11:   aset_field_next = 2'd1;
        2'b10:   aset_field_next = 2'd2;
        default: aset_field_next = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_reg     <= MODE_CLOCK;
      sub_reg      <= 2'b00;
      stw_sub_reg  <= STW_IDLE;
      ringing_reg  <= 1'b0;
      ring_cnt_reg <= 6'd0;
      ring_vis_reg <= 1'b0;
      alarm_q_reg  <= 1'b1;
      state        <= 5'b00000;
      stw_en       <= 1'b0;
      stw_clr      <= 1'b0;
      lap_hold     <= 1'b0;
      aset_inc     <= 1'b0;
      aset_field   <= 2'd0;
      buzzer       <= 1'b0;
    end else begin
      mode_reg     <= mode_next;
      sub_reg      <= sub_next;
      stw_sub_reg  <= stw_sub_next;
      ringing_reg  <= ringing_next;
      ring_cnt_reg <= ring_cnt_next;
      ring_vis_reg <= ring_vis_next;
      alarm_q_reg  <= alarm_hit;
      state        <= state_next;
      stw_en       <= (stw_sub_next == STW_RUN) || (stw_sub_next == STW_LAP);
      stw_clr      <= stw_clr_next;
      lap_hold     <= (stw_sub_next == STW_LAP);
      aset_inc     <= aset_inc_next;
      aset_field   <= aset_field_next;
      buzzer       <= ringing_next;
    end
  end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl with RING_SECS = 3; expectations queued per step.
module tb_clock_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0, btn_sel = 1'b0, btn_start = 1'b0;
  logic       tick_1hz = 1'b0, alarm_hit = 1'b0;
  logic [4:0] state;
  logic       stw_en, stw_clr, lap_hold, aset_inc, buzzer;
  logic [1:0] aset_field;
  logic [11:0] obs;

  clock_mode_ctrl #(.RING_SECS(3)) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_sel(btn_sel),
    .btn_start(btn_start), .tick_1hz(tick_1hz), .alarm_hit(alarm_hit),
    .state(state), .stw_en(stw_en), .stw_clr(stw_clr), .lap_hold(lap_hold),
    .aset_inc(aset_inc), .aset_field(aset_field), .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  assign obs = {state, stw_en, stw_clr, lap_hold, aset_inc, aset_field, buzzer};

  typedef struct {
    string       tag;
    logic [11:0] val;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [11:0] pk(input logic [4:0] st, input logic en, input logic clr,
                                     input logic lap, input logic inc, input logic [1:0] fld,
                                     input logic bz);
    return {st, en, clr, lap, inc, fld, bz};
  endfunction

  // in = {rst_n, alarm_hit, btn_mode, btn_sel, btn_start, tick_1hz}
  task automatic step(input string tag, input logic [5:0] in, input logic [11:0] exp);
    exp_t e;
    @(negedge clk);
    {rst_n, alarm_hit, btn_mode, btn_sel, btn_start, tick_1hz} = in;
    sb.push_back('{tag, exp});
    @(posedge clk);
    #1;
    btn_mode = 1'b0; btn_sel = 1'b0; btn_start = 1'b0; tick_1hz = 1'b0;
    e = sb.pop_front();
    checks++;
    assert (obs === e.val) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.val);
    end
    $display("step %-12s in=%b out=%b", e.tag, in, obs);
  endtask

  initial begin
    step("reset",      6'b000000, pk(5'b00000, 0, 0, 0, 0, 2'd0, 0));
    step("mode_stw",   6'b101000, pk(5'b10000, 0, 0, 0, 0, 2'd0, 0));
    step("mode_aset",  6'b101000, pk(5'b01000, 0, 0, 0, 0, 2'd0, 0));
    step("mode_clock", 6'b101000, pk(5'b00000, 0, 0, 0, 0, 2'd0, 0));
    step("clk_sel_b",  6'b100100, pk(5'b00010, 0, 0, 0, 0, 2'd0, 0));
    step("clk_sel_c",  6'b100100, pk(5'b00100, 0, 0, 0, 0, 2'd0, 0));
    step("clk_sel_a",  6'b100100, pk(5'b00000, 0, 0, 0, 0, 2'd0, 0));
    step("clk_start",  6'b100010, pk(5'b00000, 0, 0, 0, 0, 2'd0, 0));
    step("to_stw",     6'b101000, pk(5'b10000, 0, 0, 0, 0, 2'd0, 0));
    step("stw_run",    6'b100010, pk(5'b10010, 1, 0, 0, 0, 2'd0, 0));
    step("stw_lap",    6'b100100, pk(5'b10100, 1, 0, 1, 0, 2'd0, 0));
    step("lap_start",  6'b100010, pk(5'b10100, 1, 0, 1, 0, 2'd0, 0));
    step("lap_run",    6'b100100, pk(5'b10010, 1, 0, 0, 0, 2'd0, 0));
    step("stw_pause",  6'b100010, pk(5'b10110, 0, 0, 0, 0, 2'd0, 0));
    step("stw_clr",    6'b100100, pk(5'b10000, 0, 1, 0, 0, 2'd0, 0));
    step("clr_end",    6'b100000, pk(5'b10000, 0, 0, 0, 0, 2'd0, 0));
    step("idle_sel",   6'b100100, pk(5'b10000, 0, 0, 0, 0, 2'd0, 0));
    step("run_again",  6'b100010, pk(5'b10010, 1, 0, 0, 0, 2'd0, 0));
    step("leave_run",  6'b101000, pk(5'b01000, 1, 0, 0, 0, 2'd0, 0));
    step("clock_run",  6'b101000, pk(5'b00000, 1, 0, 0, 0, 2'd0, 0));
    step("restore",    6'b101000, pk(5'b10010, 1, 0, 0, 0, 2'd0, 0));
    step("pause2",     6'b100010, pk(5'b10110, 0, 0, 0, 0, 2'd0, 0));
    step("clr2",       6'b100100, pk(5'b10000, 0, 1, 0, 0, 2'd0, 0));
    step("clr2_end",   6'b100000, pk(5'b10000, 0, 0, 0, 0, 2'd0, 0));
    step("to_aset",    6'b101000, pk(5'b01000, 0, 0, 0, 0, 2'd0, 0));
    step("aset_f0",    6'b100100, pk(5'b01010, 0, 0, 0, 0, 2'd0, 0));
    step("aset_f1",    6'b100100, pk(5'b01110, 0, 0, 0, 0, 2'd1, 0));
    step("aset_inc",   6'b100010, pk(5'b01110, 0, 0, 0, 1, 2'd1, 0));
    step("inc_end",    6'b100000, pk(5'b01110, 0, 0, 0, 0, 2'd1, 0));
    step("aset_f2",    6'b100100, pk(5'b01100, 0, 0, 0, 0, 2'd2, 0));
    step("aset_view",  6'b100100, pk(5'b01000, 0, 0, 0, 0, 2'd0, 0));
    step("view_start", 6'b100010, pk(5'b01000, 0, 0, 0, 0, 2'd0, 0));
    step("back_clock", 6'b101000, pk(5'b00000, 0, 0, 0, 0, 2'd0, 0));
    step("page_b",     6'b100100, pk(5'b00010, 0, 0, 0, 0, 2'd0, 0));
    step("ring_start", 6'b110000, pk(5'b00011, 0, 0, 0, 0, 2'd0, 1));
    step("ring_tick1", 6'b110001, pk(5'b00010, 0, 0, 0, 0, 2'd0, 1));
    step("ring_tick2", 6'b110001, pk(5'b00011, 0, 0, 0, 0, 2'd0, 1));
    step("ring_hold",  6'b110000, pk(5'b00011, 0, 0, 0, 0, 2'd0, 1));
    step("ring_tick3", 6'b110001, pk(5'b00010, 0, 0, 0, 0, 2'd0, 0));
    step("alarm_low",  6'b100000, pk(5'b00010, 0, 0, 0, 0, 2'd0, 0));
    step("ring2",      6'b110000, pk(5'b00011, 0, 0, 0, 0, 2'd0, 1));
    step("dismiss",    6'b110100, pk(5'b00010, 0, 0, 0, 0, 2'd0, 0));
    step("alarm_low2", 6'b100000, pk(5'b00010, 0, 0, 0, 0, 2'd0, 0));
    step("stw_idle",   6'b101000, pk(5'b10000, 0, 0, 0, 0, 2'd0, 0));
    step("stw_ring",   6'b110000, pk(5'b10000, 0, 0, 0, 0, 2'd0, 1));
    step("stw_rtick",  6'b110001, pk(5'b10000, 0, 0, 0, 0, 2'd0, 1));
    step("stw_dismis", 6'b110010, pk(5'b10000, 0, 0, 0, 0, 2'd0, 0));
    step("mode_sel",   6'b101100, pk(5'b01000, 0, 0, 0, 0, 2'd0, 0));
    step("btn_edge",   6'b111000, pk(5'b00001, 0, 0, 0, 0, 2'd0, 1));
    step("rst_ring",   6'b010000, pk(5'b00000, 0, 0, 0, 0, 2'd0, 0));
    step("hit_rst1",   6'b110000, pk(5'b00000, 0, 0, 0, 0, 2'd0, 0));
    step("hit_rst2",   6'b110000, pk(5'b00000, 0, 0, 0, 0, 2'd0, 0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
